// File: rtl/i2s_dac_serializer.sv
// i2s_dac_serializer
//   Serialises parallel stereo samples to an I2S DAC. The block is the master
//   for BCLK and LRCLK, which are both divided down from clk. Both channels are
//   latched once per frame, and a one-clk sample_req pulse marks each latch.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   enable         run request (level); sampled in IDLE and at frame boundaries
//   audio_left_in  signed left sample  [DATA_WIDTH-1:0]
//   audio_right_in signed right sample [DATA_WIDTH-1:0]
//   sample_req     one-clk pulse on every latch edge
//   dac_bclk       I2S bit clock (period 2*BCLK_DIV clk)
//   dac_lrclk      word select, 0 = left slot, 1 = right slot
//   dac_data       serial data; dac_bclk, dac_lrclk and dac_data change on the
//                  same clk edge as BCLK falls
//
// Build option
//   I2S_DAC_LEFT_JUSTIFIED_EN : when defined, the MSB is placed at slot
//   position 0 (left-justified). When undefined, the MSB is placed at
//   position 1 (standard I2S).
module i2s_dac_serializer #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_WIDTH = 32,
   parameter int BCLK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] audio_left_in,
   input  logic [DATA_WIDTH-1:0] audio_right_in,
   output logic                  sample_req,
   output logic                  dac_bclk,
   output logic                  dac_lrclk,
   output logic                  dac_data
);

   localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state, state_n;
   logic [DIV_W-1:0]      div_cnt, div_n;
   logic [BIT_W-1:0]      bit_cnt, bit_n, bit_inc;
   logic [DATA_WIDTH-1:0] shadow_l, shadow_r, shl_n, shr_n;
   logic                  req_n, bclk_n, lr_n, data_n;
   int unsigned           inc_i, pos_i;

   // Serial bit for slot position p of a sample.
   function automatic logic slot_bit(input logic [DATA_WIDTH-1:0] sh,
                                     input int unsigned p);
      logic b;
      b = 1'b0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
`ifdef I2S_DAC_LEFT_JUSTIFIED_EN
         if (p == DATA_WIDTH - 1 - i) b = sh[i];
`else
         if (p == DATA_WIDTH - i) b = sh[i];
`endif
      end
      return b;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shadow_l   <= '0;
         shadow_r   <= '0;
         sample_req <= 1'b0;
         dac_bclk   <= 1'b0;
         dac_lrclk  <= 1'b0;
         dac_data   <= 1'b0;
      end else begin
         state      <= state_n;
         div_cnt    <= div_n;
         bit_cnt    <= bit_n;
         shadow_l   <= shl_n;
         shadow_r   <= shr_n;
         sample_req <= req_n;
         dac_bclk   <= bclk_n;
         dac_lrclk  <= lr_n;
         dac_data   <= data_n;
      end
   end

   always_comb begin
      state_n = state;
      div_n   = div_cnt;
      bit_n   = bit_cnt;
      shl_n   = shadow_l;
      shr_n   = shadow_r;
      req_n   = 1'b0;
      bclk_n  = dac_bclk;
      lr_n    = dac_lrclk;
      data_n  = dac_data;

      bit_inc = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      inc_i   = 32'(bit_inc);
      pos_i   = (inc_i >= SLOT_WIDTH) ? inc_i - SLOT_WIDTH : inc_i;

      case (state)
         IDLE: begin
            if (enable) begin
               state_n = RUN;
               shl_n   = audio_left_in;
               shr_n   = audio_right_in;
               req_n   = 1'b1;
               bit_n   = '0;
               div_n   = '0;
               bclk_n  = 1'b0;
               lr_n    = 1'b0;
               data_n  = slot_bit(audio_left_in, 0);
            end
         end
         RUN: begin
            if (div_cnt == DIV_LAST) begin
               div_n  = '0;
               bclk_n = ~dac_bclk;
               // BCLK is high, so this wrap is the falling edge: advance the bit.
               if (dac_bclk) begin
                  bit_n  = bit_inc;
                  lr_n   = (inc_i >= SLOT_WIDTH);
                  data_n = slot_bit((inc_i >= SLOT_WIDTH) ? shadow_r : shadow_l, pos_i);
                  if (bit_inc == '0) begin
                     if (enable) begin
                        // Position 0 of the new frame is driven from the
                        // freshly latched left sample, not the old shadow.
                        shl_n  = audio_left_in;
                        shr_n  = audio_right_in;
                        req_n  = 1'b1;
                        data_n = slot_bit(audio_left_in, 0);
                     end else begin
                        state_n = IDLE;
                        bclk_n  = 1'b0;
                        lr_n    = 1'b0;
                        data_n  = 1'b0;
                     end
                  end
               end
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
module tb_i2s_dac_serializer;

   localparam int DW    = 24;
   localparam int SW    = 32;
   localparam int D     = 4;
   localparam int FRAME = 4 * D * SW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] left_in = '0;
   logic [DW-1:0] right_in = '0;
   logic          sample_req, dac_bclk, dac_lrclk, dac_data;

   int errors = 0;
   int checks = 0;

   i2s_dac_serializer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(D)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable         (enable),
      .audio_left_in  (left_in),
      .audio_right_in (right_in),
      .sample_req     (sample_req),
      .dac_bclk       (dac_bclk),
      .dac_lrclk      (dac_lrclk),
      .dac_data       (dac_data)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: m_t counts clk edges since the most recent latch edge.
   // Every output is a pure function of m_t and the latched samples.
   bit            m_run;
   int            m_t;
   logic [DW-1:0] m_l, m_r;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_run = 1'b0;
         m_t   = 0;
         m_l   = '0;
         m_r   = '0;
      end else if (!m_run) begin
         if (enable) begin
            m_run = 1'b1;
            m_t = 0;
            m_l = left_in;
            m_r = right_in;
         end
      end else begin
         m_t++;
         if (m_t == FRAME) begin
            if (enable) begin
               m_t = 0;
               m_l = left_in;
               m_r = right_in;
            end else begin
               m_run = 1'b0;
            end
         end
      end
   end

   function automatic logic exp_data(input int t, input logic [DW-1:0] l, input logic [DW-1:0] r);
      int            k, p;
      logic [DW-1:0] sh;
      k  = t / (2 * D);
      p  = k % SW;
      sh = (k < SW) ? l : r;
`ifdef I2S_DAC_LEFT_JUSTIFIED_EN
      if (p < DW) begin
         sh = sh >> (DW - 1 - p);
         return sh[0];
      end
`else
      if (p >= 1 && p <= DW) begin
         sh = sh >> (DW - p);
         return sh[0];
      end
`endif
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      chk1("bclk", dac_bclk, m_run && ((m_t / D) % 2 == 1));
      chk1("lrclk", dac_lrclk, m_run && (m_t / (2 * D) >= SW));
      chk1("data", dac_data, m_run && exp_data(m_t, m_l, m_r));
      chk1("req", sample_req, m_run && (m_t == 0));
   end

   task automatic wait_req(output int n);
      bit ok;
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         n++;
         if (sample_req) begin
            ok = 1'b1;
            break;
         end
      end
      chk1("req_timeout", ok, 1'b1);
   endtask

   // Entered on the negedge right after a latch edge (t=0); samples
   // positions 0..63 at mid-bit and ends at t=508.
   task automatic capture(output logic [63:0] v);
      for (int k = 0; k < 64; k++) begin
         repeat ((k == 0) ? 4 : 8) @(negedge clk);
         v[63 - k] = dac_data;
      end
   endtask

   function automatic logic [63:0] frame_bits(input logic [DW-1:0] l, input logic [DW-1:0] r);
`ifdef I2S_DAC_LEFT_JUSTIFIED_EN
      return {l, 8'h00, r, 8'h00};
`else
      return {1'b0, l, 7'h00, 1'b0, r, 7'h00};
`endif
   endfunction

   initial begin
      int          n, cnt;
      logic [63:0] cap;

      // Reset held with enable high.
      enable = 1'b1;
      repeat (10) @(negedge clk);
      chk1("rst_bclk", dac_bclk, 1'b0);
      chk1("rst_data", dac_data, 1'b0);
      enable  = 1'b0;
      reset_n = 1'b1;
      cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (sample_req) cnt++;
      end
      chkn("idle_no_req", cnt, 0);

      // Known pattern.
      left_in  = 24'h800001;
      right_in = 24'h7FFFFE;
      enable   = 1'b1;
      wait_req(n);
      chkn("entry_latency", n, 1);
      capture(cap);
      chk64("frame_bits_a", cap, frame_bits(24'h800001, 24'h7FFFFE));
      wait_req(n);
      chkn("req_after_capture", n, 4);

      // Mid-frame input change at left p=10.
      repeat (84) @(negedge clk);
      left_in  = 24'h123456;
      right_in = 24'h123456;
      wait_req(n);
      chkn("req_gap_split", 84 + n, FRAME);
      capture(cap);
      chk64("frame_bits_c", cap, frame_bits(24'h123456, 24'h123456));
      wait_req(n);
      wait_req(n);
      chkn("req_period", n, FRAME);

      // Random inputs and occasional enable toggles.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) left_in = DW'($urandom);
         if ($urandom_range(0, 9) == 0) right_in = DW'($urandom);
         if ($urandom_range(0, 399) == 0) enable = ~enable;
      end

      // Enable drop at bit_cnt=20.
      left_in = 24'h800001;
      enable  = 1'b1;
      wait_req(n);
      repeat (162) @(negedge clk);
      enable = 1'b0;
      repeat (511 - 162) @(negedge clk);
      chk1("drop_last_bclk", dac_bclk, 1'b1);
      @(negedge clk);
      chk1("drop_idle_bclk", dac_bclk, 1'b0);
      chk1("drop_idle_lr", dac_lrclk, 1'b0);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (sample_req || dac_bclk) cnt++;
      end
      chkn("drop_stays_idle", cnt, 0);
      enable = 1'b1;
      wait_req(n);
      chkn("reenter_latency", n, 1);

      // Asynchronous reset at bit_cnt=40.
      repeat (40 * 8 + 3) @(negedge clk);
      chk1("pre_rst_lrclk", dac_lrclk, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk1("async_bclk", dac_bclk, 1'b0);
      chk1("async_lrclk", dac_lrclk, 1'b0);
      chk1("async_data", dac_data, 1'b0);
      chk1("async_req", sample_req, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_req(n);
      chkn("restart_latency", n, 1);
      repeat (8) @(negedge clk);
`ifdef I2S_DAC_LEFT_JUSTIFIED_EN
      chk1("restart_bit_t8", dac_data, 1'b0);
`else
      chk1("restart_msb_t8", dac_data, 1'b1);
`endif

      enable = 1'b0;
      repeat (600) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
